rs_encoder_stream: RTL and testbench



---
 rtl/rs_encoder_stream.sv | 117 +++++++++++
 tb/tb_rs_encoder_stream.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_encoder_stream.sv
// rs_encoder_stream: streaming systematic Reed-Solomon encoder over GF(2^8) with valid/ready handshake
module rs_encoder_stream #(
    parameter int         NPAR = 4,
    parameter int         K    = 64,
    parameter int         FCR  = 0,
    parameter logic [7:0] PRIM = 8'h1d
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    input  logic       s_last,
    output logic       s_ready,
    output logic [7:0] m_data,
    output logic       m_valid,
    input  logic       m_ready,
    output logic       m_last,
    output logic       m_parity,
    output logic       err_len
);
    localparam int CW = $clog2(K + 1);
    localparam int PW = $clog2(NPAR + 1);

    typedef enum logic {MSG, PARITY} state_t;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? PRIM : 8'h00);
        end
        return p;
    endfunction

    // Low NPAR coefficients of the monic g(x) = prod (x + alpha^(FCR+i))
    function automatic logic [NPAR-1:0][7:0] gen_poly();
        logic [NPAR:0][7:0] g;
        logic [7:0]         r;
        r = 8'h01;
        for (int i = 0; i < FCR; i++) r = gf_mul(r, 8'h02);
        g    = '0;
        g[0] = 8'h01;
        for (int i = 0; i < NPAR; i++) begin
            for (int j = NPAR; j > 0; j--) g[j] = g[j-1] ^ gf_mul(g[j], r);
            g[0] = gf_mul(g[0], r);
            r    = gf_mul(r, 8'h02);
        end
        return g[NPAR-1:0];
    endfunction

    localparam logic [NPAR-1:0][7:0] GEN = gen_poly();

    state_t                 state, state_nx;
    logic [NPAR-1:0][7:0]   par, par_sh, par_upd;
    logic [CW-1:0]          cnt;
    logic [PW-1:0]          pcnt;
    logic [7:0]             fb;
    logic                   adv, accept, last_in, err_hit, par_step, par_done;

    // Handshake, next state and the LFSR division step
    always_comb begin
        adv      = !m_valid || m_ready;
        s_ready  = rst_n && state == MSG && adv;
        accept   = s_valid && s_ready;
        last_in  = accept && (s_last || cnt == CW'(K - 1));
        err_hit  = accept && !s_last && cnt == CW'(K - 1);
        par_step = state == PARITY && adv;
        par_done = par_step && pcnt == PW'(NPAR - 1);
        state_nx = last_in ? PARITY : par_done ? MSG : state;
        fb       = s_data ^ par[NPAR-1];
        par_sh   = {par[NPAR-2:0], 8'h00};
        for (int i = 0; i < NPAR; i++) par_upd[i] = par_sh[i] ^ gf_mul(fb, GEN[i]);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= MSG;
        else        state <= state_nx;
    end

    // Output register, parity shift register and counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_data   <= 8'h00;
            m_valid  <= 1'b0;
            m_last   <= 1'b0;
            m_parity <= 1'b0;
            err_len  <= 1'b0;
            par      <= '0;
            cnt      <= '0;
            pcnt     <= '0;
        end else begin
            err_len <= err_hit;
            if (accept) begin
                m_data   <= s_data;
                m_valid  <= 1'b1;
                m_parity <= 1'b0;
                m_last   <= 1'b0;
                par      <= par_upd;
                cnt      <= last_in ? '0 : cnt + CW'(1);
                pcnt     <= '0;
            end else if (par_step) begin
                m_data   <= par[NPAR-1];
                m_valid  <= 1'b1;
                m_parity <= 1'b1;
                m_last   <= par_done;
                par      <= par_sh;
                pcnt     <= par_done ? '0 : pcnt + PW'(1);
            end else if (adv) begin
                m_valid  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_rs_encoder_stream.sv
// tb_rs_encoder_stream: directed table, corner sequences and syndrome checks for rs_encoder_stream
module tb_rs_encoder_stream;
    logic       clk, rst_n;
    logic [7:0] s_data;
    logic       s_valid, s_last, mr_dir, rnd_rdy, rnd_val, sel;
    logic       m_ready;
    logic       s_valid_a, s_ready_a, m_valid_a, m_last_a, m_parity_a, err_len_a;
    logic       s_valid_b, s_ready_b, m_valid_b, m_last_b, m_parity_b, err_len_b;
    logic [7:0] m_data_a, m_data_b;
    logic       cur_srdy, cur_mv, cur_mp, cur_ml, cur_err;
    logic [7:0] cur_md;

    int total = 0;
    int bad   = 0;
    int err_n = 0;
    int err_pos = -1;

    typedef struct packed { logic [7:0] d; logic p; logic l; } sym_t;
    sym_t       out_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] gexp [0:254];
    int         glog [0:255];

    typedef struct {
        logic sv; logic [7:0] sd; logic sl; logic mr;
        logic mv; logic [7:0] md; logic mp; logic ml; logic sr;
    } vec_t;
    vec_t tbl [22];

    assign m_ready   = rnd_rdy ? rnd_val : mr_dir;
    assign s_valid_a = s_valid && !sel;
    assign s_valid_b = s_valid && sel;
    assign cur_srdy  = sel ? s_ready_b  : s_ready_a;
    assign cur_mv    = sel ? m_valid_b  : m_valid_a;
    assign cur_md    = sel ? m_data_b   : m_data_a;
    assign cur_mp    = sel ? m_parity_b : m_parity_a;
    assign cur_ml    = sel ? m_last_b   : m_last_a;
    assign cur_err   = sel ? err_len_b  : err_len_a;

    rs_encoder_stream dut_a (
        .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid_a), .s_last(s_last),
        .s_ready(s_ready_a), .m_data(m_data_a), .m_valid(m_valid_a), .m_ready(m_ready),
        .m_last(m_last_a), .m_parity(m_parity_a), .err_len(err_len_a)
    );

    rs_encoder_stream #(.NPAR(16), .K(239), .FCR(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid_b), .s_last(s_last),
        .s_ready(s_ready_b), .m_data(m_data_b), .m_valid(m_valid_b), .m_ready(m_ready),
        .m_last(m_last_b), .m_parity(m_parity_b), .err_len(err_len_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        rnd_val = ($urandom_range(0, 3) != 0);
    end

    always @(negedge clk) begin
        if (cur_err) begin
            err_n   = err_n + 1;
            err_pos = out_q.size();
        end
        if (cur_mv && m_ready) out_q.push_back({cur_md, cur_mp, cur_ml});
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic vec_t v(input int sv, sd, sl, mr, mv, md, mp, ml, sr);
        vec_t r;
        r.sv = 1'(sv); r.sd = 8'(sd); r.sl = 1'(sl); r.mr = 1'(mr);
        r.mv = 1'(mv); r.md = 8'(md); r.mp = 1'(mp); r.ml = 1'(ml); r.sr = 1'(sr);
        return r;
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        if (a == 8'h00 || b == 8'h00) return 8'h00;
        return gexp[(glog[a] + glog[b]) % 255];
    endfunction

    task automatic push(input logic [7:0] d, input logic l, input bit gaps);
        int  n;
        bit  done;
        if (gaps) begin
            while ($urandom_range(0, 3) == 0) begin
                s_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
        s_data  = d;
        s_last  = l;
        s_valid = 1'b1;
        n    = 0;
        done = 1'b0;
        while (!done) begin
            @(negedge clk);
            done = cur_srdy;
            @(posedge clk); #1;
            n++;
            if (!done && n > 2000) begin
                total++; bad++;
                $display("FAIL push_timeout: s_ready stayed 0 for %0d cycles, required 1", n);
                done = 1'b1;
            end
        end
    endtask

    task automatic check_out(input string nm, input int n, input int npar);
        int c;
        c = 0;
        while (out_q.size() < n && c < 4000) begin
            @(posedge clk);
            c++;
        end
        repeat (6) @(posedge clk);
        #1;
        total++;
        if (out_q.size() != n) begin
            bad++;
            $display("FAIL %s_count: got %0d symbols, required %0d", nm, out_q.size(), n);
        end else begin
            for (int i = 0; i < n; i++) begin
                logic ep, el, dok;
                ep  = (i >= n - npar);
                el  = (i == n - 1);
                dok = (i >= exp_q.size()) || (out_q[i].d == exp_q[i]);
                total++;
                if (out_q[i].p != ep || out_q[i].l != el || !dok) begin
                    bad++;
                    $display("FAIL %s_sym%0d: got d=%0d p=%0b l=%0b, required d=%0d p=%0b l=%0b", nm, i,
                             out_q[i].d, out_q[i].p, out_q[i].l, (i < exp_q.size()) ? exp_q[i] : out_q[i].d, ep, el);
                end
            end
        end
    endtask

    task automatic syn_check(input string nm, input int npar, input int fcr);
        for (int j = 0; j < npar; j++) begin
            logic [7:0] s, r;
            s = 8'h00;
            r = gexp[(fcr + j) % 255];
            for (int i = 0; i < out_q.size(); i++) s = gmul(s, r) ^ out_q[i].d;
            total++;
            if (s != 8'h00) begin
                bad++;
                $display("FAIL %s_syndrome%0d: got %0d, required 0", nm, j, s);
            end
        end
    endtask

    initial begin
        logic [7:0] x;
        logic [31:0] act, expv;
        int n0;
        rst_n = 1'b0; s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0;
        mr_dir = 1'b1; rnd_rdy = 1'b0; sel = 1'b0;
        x = 8'h01;
        for (int i = 0; i < 255; i++) begin
            gexp[i] = x;
            glog[x] = i;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1d : 8'h00);
        end

        tbl[0]  = v(1, 'h01, 1, 1, 0, 0,   0, 0, 1);
        tbl[1]  = v(0, 'hAA, 1, 1, 1, 1,   0, 0, 0);
        tbl[2]  = v(1, 'h77, 0, 1, 1, 15,  1, 0, 0);
        tbl[3]  = v(0, 'hAA, 0, 1, 1, 54,  1, 0, 0);
        tbl[4]  = v(0, 'hAA, 1, 1, 1, 120, 1, 0, 0);
        tbl[5]  = v(1, 'h02, 1, 1, 1, 64,  1, 1, 1);
        tbl[6]  = v(0, 'h55, 0, 1, 1, 2,   0, 0, 0);
        tbl[7]  = v(0, 0,    0, 1, 1, 30,  1, 0, 0);
        tbl[8]  = v(0, 0,    0, 1, 1, 108, 1, 0, 0);
        tbl[9]  = v(0, 0,    0, 1, 1, 240, 1, 0, 0);
        tbl[10] = v(0, 'hAA, 1, 1, 1, 128, 1, 1, 1);
        tbl[11] = v(0, 'hAA, 1, 1, 0, 0,   0, 0, 1);
        tbl[12] = v(1, 'h01, 1, 1, 0, 0,   0, 0, 1);
        tbl[13] = v(0, 0,    0, 1, 1, 1,   0, 0, 0);
        tbl[14] = v(0, 0,    0, 1, 1, 15,  1, 0, 0);
        tbl[15] = v(0, 0,    0, 0, 1, 54,  1, 0, 0);
        tbl[16] = v(1, 'h33, 1, 0, 1, 54,  1, 0, 0);
        tbl[17] = v(0, 0,    0, 0, 1, 54,  1, 0, 0);
        tbl[18] = v(0, 0,    0, 1, 1, 54,  1, 0, 0);
        tbl[19] = v(0, 0,    0, 1, 1, 120, 1, 0, 0);
        tbl[20] = v(0, 0,    0, 1, 1, 64,  1, 1, 1);
        tbl[21] = v(0, 0,    0, 1, 0, 0,   0, 0, 1);

        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({m_valid_a, m_data_a, m_last_a, m_parity_a, err_len_a, s_ready_a, m_valid_b, s_ready_b} != 14'h0) begin
            bad++;
            $display("FAIL reset: got mv=%0b md=%0d ml=%0b mp=%0b err=%0b srdy=%0b mvb=%0b srdyb=%0b, required all 0",
                     m_valid_a, m_data_a, m_last_a, m_parity_a, err_len_a, s_ready_a, m_valid_b, s_ready_b);
        end
        rst_n = 1'b1;

        for (int i = 0; i < 22; i++) begin
            s_valid = tbl[i].sv; s_data = tbl[i].sd; s_last = tbl[i].sl; mr_dir = tbl[i].mr;
            @(negedge clk);
            act  = {14'h0, m_valid_a, m_valid_a ? m_data_a : 8'h00, m_valid_a && m_parity_a,
                    m_valid_a && m_last_a, s_ready_a, err_len_a};
            expv = {14'h0, tbl[i].mv, tbl[i].mv ? tbl[i].md : 8'h00, tbl[i].mv && tbl[i].mp,
                    tbl[i].mv && tbl[i].ml, tbl[i].sr, 1'b0};
            total++;
            if (act != expv) begin
                bad++;
                $display("FAIL row%0d: got mv=%0b md=%0d mp=%0b ml=%0b srdy=%0b err=%0b, required mv=%0b md=%0d mp=%0b ml=%0b srdy=%0b err=0",
                         i, m_valid_a, m_data_a, m_parity_a, m_last_a, s_ready_a, err_len_a,
                         tbl[i].mv, tbl[i].md, tbl[i].mp, tbl[i].ml, tbl[i].sr);
            end
            @(posedge clk); #1;
        end
        s_valid = 1'b0; mr_dir = 1'b1;
        @(posedge clk); #1;

        out_q.delete(); exp_q.delete();
        for (int i = 0; i < 14; i++) exp_q.push_back(8'h00);
        for (int i = 0; i < 10; i++) push(8'h00, i == 9, 1'b0);
        s_valid = 1'b0;
        check_out("zeros10", 14, 4);

        out_q.delete(); exp_q.delete();
        n0 = err_n;
        for (int i = 0; i < 68; i++) exp_q.push_back(8'h00);
        for (int i = 0; i < 64; i++) push(8'h00, 1'b0, 1'b0);
        s_valid = 1'b0;
        check_out("overlen", 68, 4);
        total++;
        if (err_n - n0 != 1 || err_pos != 63) begin
            bad++;
            $display("FAIL err_len: got %0d pulses at symbol %0d, required 1 pulse at symbol 63", err_n - n0, err_pos);
        end

        out_q.delete(); exp_q.delete();
        exp_q = '{8'd2, 8'd30, 8'd108, 8'd240, 8'd128};
        push(8'h02, 1'b1, 1'b0);
        s_valid = 1'b0;
        check_out("after_overlen", 5, 4);

        for (int i = 0; i < 5; i++) push(8'h11 + 8'(i), 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        total++;
        if ({m_valid_a, m_data_a, m_parity_a, m_last_a, s_ready_a} != 12'h0) begin
            bad++;
            $display("FAIL midreset: got mv=%0b md=%0d mp=%0b ml=%0b srdy=%0b, required all 0",
                     m_valid_a, m_data_a, m_parity_a, m_last_a, s_ready_a);
        end
        s_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_q.delete(); exp_q.delete();
        exp_q = '{8'd1, 8'd15, 8'd54, 8'd120, 8'd64};
        push(8'h01, 1'b1, 1'b0);
        s_valid = 1'b0;
        check_out("post_reset", 5, 4);

        rnd_rdy = 1'b1;
        for (int s = 0; s < 2; s++) begin
            sel = 1'(s);
            @(posedge clk); #1;
            for (int f = 0; f < 6; f++) begin
                int l, np;
                l  = $urandom_range(1, 64);
                np = s ? 16 : 4;
                out_q.delete(); exp_q.delete();
                for (int i = 0; i < l; i++) exp_q.push_back(8'($urandom_range(0, 255)));
                for (int i = 0; i < l; i++) push(exp_q[i], i == l - 1, 1'b1);
                s_valid = 1'b0;
                check_out(s ? "rand_b" : "rand_a", l + np, np);
                syn_check(s ? "rand_b" : "rand_a", np, s);
            end
        end
        rnd_rdy = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
